// File: rtl/gate_arbiter_pkg.sv
// Shared definitions for the parking-lot gate arbiter.
// Contents:
//   NUM_SPOTS / SPOT_W : lot size and spot index width (fixed at 4 spots)
//   state_e            : door sequencer states
//   dir_e              : direction of the current or most recent door window
//   count_free         : number of set bits in a free-spot vector
package parking_pkg;

  localparam int NUM_SPOTS = 4;
  localparam int SPOT_W    = 2;

  typedef enum logic [1:0] {
    IDLE,
    OPEN,
    CLOSE
  } state_e;

  typedef enum logic {
    ENTRY,
    EXIT
  } dir_e;

  function automatic logic [2:0] count_free(input logic [NUM_SPOTS-1:0] e);
    logic [2:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_SPOTS; i++) begin
      cnt = cnt + 3'(e[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/gate_arbiter_if.sv
// Lane/arbiter bundle for the shared barrier door.
// Lane side (master) drives:
//   enter_req, exit_req, exit_spot, car_passed
// Arbiter side (slave) drives:
//   enter_gnt, exit_gnt, door_open, alloc_spot,
//   F (occupied), E (free), capacity, full, timeout, bad_exit
interface gate_arbiter_if;
  import parking_pkg::*;

  logic                 enter_req;
  logic                 exit_req;
  logic [SPOT_W-1:0]    exit_spot;
  logic                 car_passed;

  logic                 enter_gnt;
  logic                 exit_gnt;
  logic                 door_open;
  logic [SPOT_W-1:0]    alloc_spot;
  logic [NUM_SPOTS-1:0] F;
  logic [NUM_SPOTS-1:0] E;
  logic [2:0]           capacity;
  logic                 full;
  logic                 timeout;
  logic                 bad_exit;

  modport master (
    output enter_req, exit_req, exit_spot, car_passed,
    input  enter_gnt, exit_gnt, door_open, alloc_spot,
           F, E, capacity, full, timeout, bad_exit
  );

  modport slave (
    input  enter_req, exit_req, exit_spot, car_passed,
    output enter_gnt, exit_gnt, door_open, alloc_spot,
           F, E, capacity, full, timeout, bad_exit
  );

endinterface

// File: rtl/gate_arbiter_free_spot_encoder.sv
// Lowest-index free spot finder.
// Ports:
//   E_i        : free-spot vector, bit i = spot i free
//   idx_o      : index of the lowest set bit of E_i (0 when none set)
//   any_free_o : at least one spot is free
module free_spot_encoder
  import parking_pkg::*;
(
  input  logic [NUM_SPOTS-1:0] E_i,
  output logic [SPOT_W-1:0]    idx_o,
  output logic                 any_free_o
);

  always_comb begin
    idx_o      = '0;
    any_free_o = |E_i;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = NUM_SPOTS - 1; i >= 0; i--) begin
      if (E_i[i]) begin
        idx_o = SPOT_W'(i);
      end
    end
  end

endmodule

// File: rtl/gate_arbiter.sv
// Barrier-door sequencer for a 4-spot lot shared by an entry and an exit lane.
// Arbitrates lane requests round-robin, times the door-open window, allocates
// the lowest free spot to entering cars and releases spots for exiting cars.
// Ports:
//   CLK : clock, all state updates on the rising edge
//   RST : synchronous active-high reset
//   bus : gate_arbiter_if.slave (lane requests in; grants, door, occupancy out)
// Parameters:
//   OPEN_CYCLES : longest door window waiting for car_passed (>= 2)
module gate_arbiter
  import parking_pkg::*;
#(
  parameter int OPEN_CYCLES = 8
) (
  input  logic           CLK,
  input  logic           RST,
  gate_arbiter_if.slave  bus
);

  localparam int TMR_W = (OPEN_CYCLES > 2) ? $clog2(OPEN_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(OPEN_CYCLES - 1);

  state_e               state_q;
  // Written at every grant, so it names the current window's direction while
  // OPEN and the previous winner while IDLE.
  dir_e                 last_dir_q;
  logic [TMR_W-1:0]     timer_q;
  logic [NUM_SPOTS-1:0] F_q;
  logic [NUM_SPOTS-1:0] F_d;
  logic [2:0]           cap_q;
  logic                 full_q;
  logic [SPOT_W-1:0]    alloc_q;
  logic [SPOT_W-1:0]    exit_spot_q;
  logic                 enter_gnt_q;
  logic                 exit_gnt_q;
  logic                 door_q;
  logic                 timeout_q;

  logic [NUM_SPOTS-1:0] free_vec;
  logic [SPOT_W-1:0]    free_idx;
  logic                 any_free;
  logic                 entry_elig;
  logic                 exit_elig;
  logic                 grant_entry;
  logic                 grant_exit;
  logic                 commit;

  assign free_vec = ~F_q;

  free_spot_encoder u_enc (
    .E_i        (free_vec),
    .idx_o      (free_idx),
    .any_free_o (any_free)
  );

  // any_free is the complement of the registered full flag, both track F_q.
  assign entry_elig = bus.enter_req & any_free;
  assign exit_elig  = bus.exit_req & F_q[bus.exit_spot];

  // On a tie the lane that did not win last time goes first.
  assign grant_entry = (state_q == IDLE) & entry_elig &
                       (~exit_elig | (last_dir_q == EXIT));
  assign grant_exit  = (state_q == IDLE) & exit_elig & ~grant_entry;

  // A pass-through beats window expiry in the same cycle.
  assign commit = (state_q == OPEN) & bus.car_passed;

  always_comb begin
    F_d = F_q;
    if (commit) begin
      if (last_dir_q == ENTRY) begin
        F_d[alloc_q] = 1'b1;
      end else begin
        F_d[exit_spot_q] = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      last_dir_q  <= EXIT;
      timer_q     <= '0;
      F_q         <= '0;
      cap_q       <= 3'(NUM_SPOTS);
      full_q      <= 1'b0;
      alloc_q     <= '0;
      exit_spot_q <= '0;
      enter_gnt_q <= 1'b0;
      exit_gnt_q  <= 1'b0;
      door_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      enter_gnt_q <= 1'b0;
      exit_gnt_q  <= 1'b0;
      timeout_q   <= 1'b0;
      F_q         <= F_d;
      cap_q       <= count_free(~F_d);
      full_q      <= &F_d;

      case (state_q)
        IDLE: begin
          if (grant_entry) begin
            state_q     <= OPEN;
            door_q      <= 1'b1;
            enter_gnt_q <= 1'b1;
            timer_q     <= '0;
            last_dir_q  <= ENTRY;
            alloc_q     <= free_idx;
          end else if (grant_exit) begin
            state_q     <= OPEN;
            door_q      <= 1'b1;
            exit_gnt_q  <= 1'b1;
            timer_q     <= '0;
            last_dir_q  <= EXIT;
            exit_spot_q <= bus.exit_spot;
          end
        end

        OPEN: begin
          timer_q <= timer_q + TMR_W'(1);
          if (bus.car_passed) begin
            state_q <= CLOSE;
            door_q  <= 1'b0;
          end else if (timer_q == TMR_LAST) begin
            state_q   <= CLOSE;
            door_q    <= 1'b0;
            timeout_q <= 1'b1;
          end
        end

        CLOSE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
          door_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.enter_gnt  = enter_gnt_q;
  assign bus.exit_gnt   = exit_gnt_q;
  assign bus.door_open  = door_q;
  assign bus.alloc_spot = alloc_q;
  assign bus.F          = F_q;
  assign bus.E          = ~F_q;
  assign bus.capacity   = cap_q;
  assign bus.full       = full_q;
  assign bus.timeout    = timeout_q;
  // Exit against an empty spot is flagged only while the door is idle.
  assign bus.bad_exit   = (state_q == IDLE) & bus.exit_req & ~F_q[bus.exit_spot];

endmodule

// File: tb/tb_gate_arbiter.sv
module tb_gate_arbiter;

  logic CLK;
  logic RST;

  gate_arbiter_if bus ();

  gate_arbiter #(.OPEN_CYCLES(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Event kinds as {timeout, exit_gnt, enter_gnt}
  localparam logic [2:0] EV_ENTER   = 3'b001;
  localparam logic [2:0] EV_EXIT    = 3'b010;
  localparam logic [2:0] EV_TIMEOUT = 3'b100;

  typedef struct {
    logic [2:0] kind;
    logic [1:0] spot;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] kind, input logic [1:0] spot);
    ev_t e;
    e.kind = kind;
    e.spot = spot;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard monitor: every grant/timeout pulse must match the next queued event.
  initial begin
    ev_t        e;
    logic [2:0] seen;
    forever begin
      @(negedge CLK);
      seen = {bus.timeout, bus.exit_gnt, bus.enter_gnt};
      if (seen != 3'b000) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected actual_kind=%0b expected=none t=%0t", seen, $time);
        end else begin
          e = exp_q.pop_front();
          chk("sb_kind", 32'(seen), 32'(e.kind));
          if (e.kind == EV_ENTER) begin
            chk("sb_alloc", 32'(bus.alloc_spot), 32'(e.spot));
            chk("sb_door", 32'(bus.door_open), 32'd1);
          end
          if (e.kind == EV_EXIT) begin
            chk("sb_door", 32'(bus.door_open), 32'd1);
          end
        end
      end
    end
  end

  task automatic do_entry(input logic [1:0] spot);
    push(EV_ENTER, spot);
    bus.enter_req = 1'b1;
    tick();
    bus.enter_req  = 1'b0;
    bus.car_passed = 1'b1;
    tick();
    bus.car_passed = 1'b0;
    chk("entry_close_door", 32'(bus.door_open), 32'd0);
    tick();
  endtask

  task automatic do_exit(input logic [1:0] spot);
    push(EV_EXIT, 2'd0);
    bus.exit_req  = 1'b1;
    bus.exit_spot = spot;
    tick();
    bus.exit_req   = 1'b0;
    bus.car_passed = 1'b1;
    tick();
    bus.car_passed = 1'b0;
    tick();
  endtask

  initial begin
    int door_cnt;
    RST            = 1'b1;
    bus.enter_req  = 1'b0;
    bus.exit_req   = 1'b0;
    bus.exit_spot  = 2'd0;
    bus.car_passed = 1'b0;
    tick();
    tick();
    RST = 1'b0;

    // Reset state
    chk("rst_F", 32'(bus.F), 32'h0);
    chk("rst_E", 32'(bus.E), 32'hF);
    chk("rst_cap", 32'(bus.capacity), 32'd4);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_door", 32'(bus.door_open), 32'd0);
    chk("rst_alloc", 32'(bus.alloc_spot), 32'd0);
    chk("rst_bad_exit", 32'(bus.bad_exit), 32'd0);

    // Single entry: grant one cycle after request, commit after car_passed
    push(EV_ENTER, 2'd0);
    bus.enter_req = 1'b1;
    tick();
    bus.enter_req = 1'b0;
    chk("t1_door_open", 32'(bus.door_open), 32'd1);
    tick();
    tick();
    chk("t1_F_before", 32'(bus.F), 32'h0);
    bus.car_passed = 1'b1;
    tick();
    bus.car_passed = 1'b0;
    chk("t1_F", 32'(bus.F), 32'h1);
    chk("t1_cap", 32'(bus.capacity), 32'd3);
    chk("t1_close_door", 32'(bus.door_open), 32'd0);
    tick();
    chk("t1_idle_door", 32'(bus.door_open), 32'd0);

    // Fill the lot
    do_entry(2'd1);
    do_entry(2'd2);
    do_entry(2'd3);
    chk("full_F", 32'(bus.F), 32'hF);
    chk("full_E", 32'(bus.E), 32'h0);
    chk("full_cap", 32'(bus.capacity), 32'd0);
    chk("full_flag", 32'(bus.full), 32'd1);

    // Entry held on a full lot: no grant for 20 cycles
    bus.enter_req = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("full_no_door", 32'(bus.door_open), 32'd0);

    // Exit spot 2 frees the lot, then the held entry takes spot 2
    push(EV_EXIT, 2'd0);
    bus.exit_req  = 1'b1;
    bus.exit_spot = 2'd2;
    tick();
    bus.exit_req   = 1'b0;
    bus.car_passed = 1'b1;
    tick();
    bus.car_passed = 1'b0;
    chk("exit2_F", 32'(bus.F), 32'hB);
    chk("exit2_full", 32'(bus.full), 32'd0);
    chk("exit2_cap", 32'(bus.capacity), 32'd1);
    push(EV_ENTER, 2'd2);
    tick();
    tick();
    bus.enter_req = 1'b0;
    chk("pend_alloc", 32'(bus.alloc_spot), 32'd2);
    bus.car_passed = 1'b1;
    tick();
    bus.car_passed = 1'b0;
    chk("pend_F", 32'(bus.F), 32'hF);
    tick();

    // Make room for the alternation test: F = 1100
    do_exit(2'd0);
    do_exit(2'd1);
    chk("pre_alt_F", 32'(bus.F), 32'hC);
    chk("pre_alt_cap", 32'(bus.capacity), 32'd2);

    // Both lanes held, no car passes: grants alternate, each window times out
    push(EV_ENTER, 2'd0);
    push(EV_TIMEOUT, 2'd0);
    push(EV_EXIT, 2'd0);
    push(EV_TIMEOUT, 2'd0);
    push(EV_ENTER, 2'd0);
    push(EV_TIMEOUT, 2'd0);
    push(EV_EXIT, 2'd0);
    push(EV_TIMEOUT, 2'd0);
    bus.enter_req = 1'b1;
    bus.exit_req  = 1'b1;
    bus.exit_spot = 2'd3;
    for (int i = 0; i < 31; i++) tick();
    bus.enter_req = 1'b0;
    bus.exit_req  = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("alt_F", 32'(bus.F), 32'hC);

    // Entry window expiring: door open exactly 8 cycles, spot reused after
    push(EV_ENTER, 2'd0);
    push(EV_TIMEOUT, 2'd0);
    bus.enter_req = 1'b1;
    tick();
    bus.enter_req = 1'b0;
    door_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.door_open) door_cnt++;
      tick();
    end
    chk("to_door_cycles", 32'(door_cnt), 32'd8);
    chk("to_F", 32'(bus.F), 32'hC);
    do_entry(2'd0);
    chk("to_reuse_F", 32'(bus.F), 32'hD);

    // Exit naming a free spot is flagged and never granted
    bus.exit_req  = 1'b1;
    bus.exit_spot = 2'd1;
    tick();
    chk("bad_exit_hi", 32'(bus.bad_exit), 32'd1);
    tick();
    tick();
    chk("bad_exit_door", 32'(bus.door_open), 32'd0);
    chk("bad_exit_held", 32'(bus.bad_exit), 32'd1);
    push(EV_EXIT, 2'd0);
    bus.exit_spot = 2'd3;
    #1;
    chk("bad_exit_lo", 32'(bus.bad_exit), 32'd0);
    tick();
    bus.exit_req   = 1'b0;
    bus.car_passed = 1'b1;
    tick();
    bus.car_passed = 1'b0;
    tick();
    chk("exit3_F", 32'(bus.F), 32'h5);

    // Reset three cycles into an entry window; car_passed during reset ignored
    push(EV_ENTER, 2'd1);
    bus.enter_req = 1'b1;
    tick();
    bus.enter_req = 1'b0;
    tick();
    tick();
    chk("rw_door_before", 32'(bus.door_open), 32'd1);
    RST            = 1'b1;
    bus.car_passed = 1'b1;
    tick();
    chk("rw_door", 32'(bus.door_open), 32'd0);
    chk("rw_F", 32'(bus.F), 32'h0);
    chk("rw_cap", 32'(bus.capacity), 32'd4);
    tick();
    RST            = 1'b0;
    bus.car_passed = 1'b0;
    tick();
    chk("rw_F_after", 32'(bus.F), 32'h0);
    chk("rw_alloc", 32'(bus.alloc_spot), 32'd0);

    tick();
    tick();
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_arbiter.md
Name: gate_arbiter

Overview:
- Sequences the single shared barrier door of the 4-spot lot between the entry lane and the exit lane.
- Arbitrates simultaneous requests round-robin and times the door-open window.
- Allocates the lowest-index free spot to an entering car and releases the named spot for an exiting car.
- Owns the occupancy vector; capacity and full are derived from it. It sits between the lane sensors/buttons and the spot display logic.

Parameters:
NUM_SPOTS, 4, number of parking spots (spot index width SPOT_W = 2, fixed for 4 spots)
OPEN_CYCLES, 8, maximum cycles the door stays open waiting for car_passed (>= 2)

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  reset, synchronous, active-high
enter_req  input  1  level request from entry lane, held until grant or withdrawn
exit_req  input  1  level request from exit lane
exit_spot  input  2  spot index the exiting car vacates, sampled at exit grant
car_passed  input  1  pass-through sensor pulse, meaningful only while door_open=1
enter_gnt  output  1  one-cycle grant pulse to entry lane
exit_gnt  output  1  one-cycle grant pulse to exit lane
door_open  output  1  door actuator
alloc_spot  output  2  spot assigned to current entering car, valid while entry window open
F  output  4  occupied-spot vector, bit i = spot i taken
E  output  4  free-spot vector, always ~F
capacity  output  3  count of free spots, 0..4
full  output  1  capacity == 0
timeout  output  1  one-cycle pulse when a door window expires without car_passed
bad_exit  output  1  high in IDLE while exit_req=1 and F[exit_spot]=0

Behaviour:
- Reset (RST=1 at edge): state=IDLE, F=0000, E=1111, capacity=4, full=0, door_open=0, enter_gnt=exit_gnt=timeout=0, alloc_spot=0, timer=0, last_dir=EXIT so entry wins the first tie. RST mid-window aborts it: door closes next cycle, and any uncommitted occupancy change is lost.
- States: IDLE, OPEN, CLOSE; plus dir register (ENTRY/EXIT).
- IDLE, eligible requests:
  - entry eligible = enter_req & ~full;
  - exit eligible = exit_req & F[exit_spot].
  - One eligible: grant it.
  - Both eligible: grant the direction opposite last_dir.
  - Neither: stay.
- On grant:
  - next cycle state=OPEN, door_open=1, matching *_gnt high for exactly that first OPEN cycle, timer=0, dir and last_dir updated.
  - Entry: alloc_spot latched = lowest-index set bit of E.
  - Exit: exit_spot latched internally.
  - Latency request→grant/door_open: 1 cycle.
- OPEN:
  - timer increments each cycle.
  - car_passed=1: commit next edge. ENTRY sets F[alloc_spot]; EXIT clears F[latched spot]. Go to CLOSE.
  - Else timer==OPEN_CYCLES-1: timeout pulse next cycle, no occupancy change, go to CLOSE.
  - car_passed and expiry in the same cycle: commit wins, no timeout.
  - Requests are ignored during OPEN/CLOSE.
- CLOSE: door_open=0 for exactly one cycle, then IDLE. A car_passed here is ignored.
- Window length: door_open high for at most OPEN_CYCLES cycles.
- Derived outputs: capacity = popcount(E); full = (capacity==0); both registered alongside F, so they are visible the cycle after commit.
- Full lot: entry never granted. An exit frees a spot, and entry is eligible from the next IDLE cycle.
- bad_exit: combinational from IDLE state, F and inputs. No grant while asserted; lane may change exit_spot.
- alloc_spot holds its value outside entry windows.

Decomposition:
- Package parking_pkg: NUM_SPOTS, SPOT_W, state enum {IDLE, OPEN, CLOSE}, dir enum {ENTRY, EXIT}.
- Sub-module free_spot_encoder: combinational priority encoder from E[3:0] to lowest free index plus any_free flag. Used for alloc_spot and reusable by display logic.

Test Plan:
- Reset then enter_req=1 at cycle 2, car_passed at cycle 5 → enter_gnt pulse + door_open at cycle 3, alloc_spot=0, F=0001 / capacity=3 at cycle 6, door_open=0 at cycle 6 (CLOSE), IDLE at 7.
- Fill 4 spots, then hold enter_req → full=1, capacity=0, no enter_gnt for 20 cycles; exit_req with exit_spot=2 + car_passed → F=1011, pending entry granted with alloc_spot=2.
- enter_req and exit_req (exit_spot occupied) asserted together, repeatedly → grants alternate ENTRY, EXIT, ENTRY…, never two in a row for one lane.
- Entry grant, no car_passed → door_open high exactly 8 cycles, timeout pulse, F unchanged, alloc_spot reused on the next entry.
- exit_req with exit_spot=3, F=0001 → bad_exit=1, no exit_gnt, door stays closed.
- RST asserted 3 cycles into an entry window → door_open=0 and F=0000, capacity=4 the cycle after; a car_passed during reset does not commit.
